// File: rtl/vga_timing.sv
// Free-running VGA raster timing generator: counters, sync/blank strobes and a
// start-of-frame pulse, all registered together so they describe the same pixel.
module vga_timing #(
  parameter int unsigned H_ACTIVE    = 1024,
  parameter int unsigned H_FP        = 24,
  parameter int unsigned H_SYNC      = 136,
  parameter int unsigned H_BP        = 160,
  parameter int unsigned V_ACTIVE    = 768,
  parameter int unsigned V_FP        = 3,
  parameter int unsigned V_SYNC      = 6,
  parameter int unsigned V_BP        = 29,
  parameter logic        SYNC_ACTIVE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic        sof_out
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_MAX      = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_MAX      = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_BLANK    = 11'(H_ACTIVE);
  localparam logic [10:0] V_BLANK    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_FIRST   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_LAST    = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] VS_FIRST   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_LAST    = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [10:0] h_next;
  logic [10:0] v_next;
  logic        line_end;
  logic        frame_end;
  logic        hsync_next;
  logic        vsync_next;

  // Strobes are decoded from the next counts so the registered outputs all
  // describe the same pixel with no skew.
  always_comb begin
    line_end   = (hcount_out == H_MAX);
    frame_end  = line_end && (vcount_out == V_MAX);
    h_next     = line_end ? '0 : hcount_out + 11'd1;
    v_next     = vcount_out;
    if (line_end) begin
      v_next = (vcount_out == V_MAX) ? '0 : vcount_out + 11'd1;
    end
    hsync_next = ((h_next >= HS_FIRST) && (h_next <= HS_LAST)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_next = ((v_next >= VS_FIRST) && (v_next <= VS_LAST)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= ~SYNC_ACTIVE;
      hblnk_out  <= 1'b0;
      vsync_out  <= ~SYNC_ACTIVE;
      vblnk_out  <= 1'b0;
      sof_out    <= 1'b0;
    end else if (ce) begin
      hcount_out <= h_next;
      vcount_out <= v_next;
      hsync_out  <= hsync_next;
      hblnk_out  <= (h_next >= H_BLANK);
      vsync_out  <= vsync_next;
      vblnk_out  <= (v_next >= V_BLANK);
      sof_out    <= frame_end;
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Scoreboard bench for vga_timing: three parameterisations share clk/rst/ce and
// are checked every cycle against a position-based raster model.
module tb_vga_timing;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        hb;
    logic        vs;
    logic        vb;
    logic        sof;
  } vout_t;

  typedef struct {
    vout_t d;
    vout_t n;
    vout_t s;
  } exp_t;

  logic clk;
  logic rst;
  logic ce;

  logic [10:0] d_h, d_v, n_h, n_v, s_h, s_v;
  logic d_hs, d_hb, d_vs, d_vb, d_sof;
  logic n_hs, n_hb, n_vs, n_vb, n_sof;
  logic s_hs, s_hb, s_vs, s_vb, s_sof;

  exp_t        sb[$];
  int unsigned pos;
  int          n_checks;
  int          n_fail;

  // Default 1024x768 mode, positive syncs
  vga_timing u_def (
    .clk(clk), .rst(rst), .ce(ce),
    .hcount_out(d_h), .vcount_out(d_v), .hsync_out(d_hs), .hblnk_out(d_hb),
    .vsync_out(d_vs), .vblnk_out(d_vb), .sof_out(d_sof)
  );

  // 640x480 mode with negative syncs
  vga_timing #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33),
    .SYNC_ACTIVE(1'b0)
  ) u_neg (
    .clk(clk), .rst(rst), .ce(ce),
    .hcount_out(n_h), .vcount_out(n_v), .hsync_out(n_hs), .hblnk_out(n_hb),
    .vsync_out(n_vs), .vblnk_out(n_vb), .sof_out(n_sof)
  );

  // Tiny raster so whole frames, vertical boundaries and sof fit in the run
  vga_timing #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .SYNC_ACTIVE(1'b1)
  ) u_sml (
    .clk(clk), .rst(rst), .ce(ce),
    .hcount_out(s_h), .vcount_out(s_v), .hsync_out(s_hs), .hblnk_out(s_hb),
    .vsync_out(s_vs), .vblnk_out(s_vb), .sof_out(s_sof)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // p = ce-qualified edges since the last reset; the raster is a pure function of it.
  function automatic vout_t model(input int unsigned p,
                                  input int unsigned ha, input int unsigned hf,
                                  input int unsigned hsw, input int unsigned hbp,
                                  input int unsigned va, input int unsigned vf,
                                  input int unsigned vsw, input int unsigned vbp,
                                  input bit sa);
    vout_t       r;
    int unsigned ht, vt, h, v;
    ht    = ha + hf + hsw + hbp;
    vt    = va + vf + vsw + vbp;
    h     = p % ht;
    v     = (p / ht) % vt;
    r.h   = 11'(h);
    r.v   = 11'(v);
    r.hb  = (h >= ha);
    r.vb  = (v >= va);
    r.hs  = (h >= ha + hf && h < ha + hf + hsw) ? sa : !sa;
    r.vs  = (v >= va + vf && v < va + vf + vsw) ? sa : !sa;
    r.sof = (p != 0) && (p % (ht * vt) == 0);
    return r;
  endfunction

  function automatic string fmt(input vout_t o);
    return $sformatf("h=%0d v=%0d hs=%b hb=%b vs=%b vb=%b sof=%b",
                     o.h, o.v, o.hs, o.hb, o.vs, o.vb, o.sof);
  endfunction

  task automatic check(input string name, input vout_t act, input vout_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %s, expected %s", name, $time, fmt(act), fmt(exp));
    end
  endtask

  // Drive one clock's inputs and push the outputs expected after that edge.
  task automatic step(input bit r, input bit c);
    exp_t e;
    @(negedge clk);
    rst = r;
    ce  = c;
    if (r) pos = 0;
    else if (c) pos++;
    e.d = model(pos, 1024, 24, 136, 160, 768, 3, 6, 29, 1'b1);
    e.n = model(pos, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
    e.s = model(pos, 16, 2, 3, 3, 8, 1, 2, 2, 1'b1);
    sb.push_back(e);
  endtask

  // Monitor: compare after every active edge for which an expectation exists.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("def_1024x768", {d_h, d_v, d_hs, d_hb, d_vs, d_vb, d_sof}, e.d);
        check("neg_640x480",  {n_h, n_v, n_hs, n_hb, n_vs, n_vb, n_sof}, e.n);
        check("small",        {s_h, s_v, s_hs, s_hb, s_vs, s_vb, s_sof}, e.s);
      end
    end
  end

  initial begin
    int guard;
    n_checks = 0;
    n_fail   = 0;
    pos      = 0;
    rst      = 1'b1;
    ce       = 1'b0;

    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);

    // Free run: several full lines of every mode, many small frames
    for (int i = 0; i < 3000; i++) step(1'b0, 1'b1);

    // One-in-three pixel enable: outputs freeze and sof stretches to 3 clocks
    for (int i = 0; i < 3000; i++) step(1'b0, (i % 3) == 0);

    // Random enable with rare random resets
    for (int i = 0; i < 20000; i++)
      step($urandom_range(0, 3999) == 0, $urandom_range(0, 3) != 0);

    // Reset while the small raster is inside both syncs
    guard = 0;
    while (!((pos % 24) == 19 && ((pos / 24) % 13) == 9) && guard < 400) begin
      step(1'b0, 1'b1);
      guard++;
    end
    n_checks++;
    if (guard >= 400) begin
      n_fail++;
      $display("FAIL seek_small_sync: got guard=%0d, expected < 400", guard);
    end
    step(1'b1, 1'b1);
    for (int i = 0; i < 50; i++) step(1'b0, 1'b1);

    // Reset in the middle of the default-mode hsync
    guard = 0;
    while ((pos % 1344) != 1100 && guard < 1400) begin
      step(1'b0, 1'b1);
      guard++;
    end
    n_checks++;
    if (guard >= 1400) begin
      n_fail++;
      $display("FAIL seek_def_hsync: got guard=%0d, expected < 1400", guard);
    end
    step(1'b1, 1'b0);
    for (int i = 0; i < 1500; i++) step(1'b0, 1'b1);

    repeat (3) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
